lane_vrf_write_sink: RTL and testbench

Per-lane VRF write-port responder. It accepts the lane's stage-3 VRF write requests over a valid/ready channel, applies byte-masked writes into a 32-register × 8-row × 32-bit slice, and serves a single-cycle-latency read port that shares the same array access slot. It reports instruction write completion when a request flagged `last` commits. It sits directly downstream of the lane's stage-3 write queue.

---
 rtl/lane_vrf_write_sink_if.sv | 52 +++++
 rtl/lane_vrf_write_sink.sv | 116 +++++++++++
 tb/tb_lane_vrf_write_sink.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lane_vrf_write_sink_if.sv
// Bundle of the lane VRF write-sink channels: write request, read request,
// read result and write-done completion.
//   master : upstream side (drives requests, observes readies/results)
//   slave  : the write sink itself
interface lane_vrf_write_sink_if #(
    parameter int unsigned VD_WIDTH     = 5,
    parameter int unsigned OFFSET_WIDTH = 3,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH  = 3
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    logic                    vrfWriteRequest_valid;
    logic                    vrfWriteRequest_ready;
    logic [VD_WIDTH-1:0]     vrfWriteRequest_bits_vd;
    logic [OFFSET_WIDTH-1:0] vrfWriteRequest_bits_offset;
    logic [MASK_WIDTH-1:0]   vrfWriteRequest_bits_mask;
    logic [DATA_WIDTH-1:0]   vrfWriteRequest_bits_data;
    logic                    vrfWriteRequest_bits_last;
    logic [INDEX_WIDTH-1:0]  vrfWriteRequest_bits_instructionIndex;

    logic                    readRequest_valid;
    logic                    readRequest_ready;
    logic [VD_WIDTH-1:0]     readRequest_bits_vs;
    logic [OFFSET_WIDTH-1:0] readRequest_bits_offset;

    logic                    readResult_valid;
    logic [DATA_WIDTH-1:0]   readResult_bits;

    logic                    writeDone_valid;
    logic [INDEX_WIDTH-1:0]  writeDone_bits_instructionIndex;

    modport master (
        output vrfWriteRequest_valid, vrfWriteRequest_bits_vd, vrfWriteRequest_bits_offset,
               vrfWriteRequest_bits_mask, vrfWriteRequest_bits_data, vrfWriteRequest_bits_last,
               vrfWriteRequest_bits_instructionIndex,
               readRequest_valid, readRequest_bits_vs, readRequest_bits_offset,
        input  vrfWriteRequest_ready, readRequest_ready,
               readResult_valid, readResult_bits,
               writeDone_valid, writeDone_bits_instructionIndex
    );

    modport slave (
        input  vrfWriteRequest_valid, vrfWriteRequest_bits_vd, vrfWriteRequest_bits_offset,
               vrfWriteRequest_bits_mask, vrfWriteRequest_bits_data, vrfWriteRequest_bits_last,
               vrfWriteRequest_bits_instructionIndex,
               readRequest_valid, readRequest_bits_vs, readRequest_bits_offset,
        output vrfWriteRequest_ready, readRequest_ready,
               readResult_valid, readResult_bits,
               writeDone_valid, writeDone_bits_instructionIndex
    );
endinterface

// File: rtl/lane_vrf_write_sink.sv
// Per-lane VRF write-port responder. Accepts byte-masked write requests into a
// 32-register x 8-row x 32-bit slice and serves a 1-cycle-latency read port
// sharing the single array access slot. Reads win contention until the write
// side has lost STARVE_LIMIT times in a row, then the write is forced through.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-low reset
//   bus    : write request / read request / read result / write-done channels
//            (only the two readies are combinational; all else registered)
module lane_vrf_write_sink #(
    parameter int unsigned VD_WIDTH     = 5,
    parameter int unsigned OFFSET_WIDTH = 3,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH  = 3,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    lane_vrf_write_sink_if.slave    bus
);
    localparam int unsigned MASK_WIDTH   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_WIDTH   = VD_WIDTH + OFFSET_WIDTH;
    localparam int unsigned DEPTH        = 1 << ADDR_WIDTH;
    localparam int unsigned STARVE_WIDTH = 2;

    logic [STARVE_WIDTH-1:0] starve_q, starve_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    done_valid_q, done_valid_d;
    logic [INDEX_WIDTH-1:0]  done_idx_q, done_idx_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    force_c;
    logic                    wr_fire_c;
    logic                    rd_fire_c;
    logic [ADDR_WIDTH-1:0]   wr_addr_c;
    logic [ADDR_WIDTH-1:0]   rd_addr_c;
    logic [DATA_WIDTH-1:0]   wr_word_c;

    // Arbitration: readies depend only on the opposite valid and starve state.
    assign force_c               = (starve_q == STARVE_WIDTH'(STARVE_LIMIT));
    assign bus.readRequest_ready = ~(bus.vrfWriteRequest_valid & force_c);
    assign bus.vrfWriteRequest_ready = ~bus.readRequest_valid | force_c;

    assign wr_fire_c = bus.vrfWriteRequest_valid & bus.vrfWriteRequest_ready;
    assign rd_fire_c = bus.readRequest_valid & bus.readRequest_ready;
    assign wr_addr_c = {bus.vrfWriteRequest_bits_vd, bus.vrfWriteRequest_bits_offset};
    assign rd_addr_c = {bus.readRequest_bits_vs, bus.readRequest_bits_offset};

    // Byte-merge of the write data over the current row contents.
    always_comb begin
        wr_word_c = mem_q[wr_addr_c];
        for (int b = 0; b < int'(MASK_WIDTH); b++) begin
            if (bus.vrfWriteRequest_bits_mask[b]) begin
                wr_word_c[8*b +: 8] = bus.vrfWriteRequest_bits_data[8*b +: 8];
            end
        end
    end

    // Next-state for starve counter and registered outputs.
    always_comb begin
        starve_d     = starve_q;
        rd_valid_d   = rd_fire_c;
        rd_data_d    = rd_data_q;
        done_valid_d = wr_fire_c & bus.vrfWriteRequest_bits_last;
        done_idx_d   = done_idx_q;

        if (wr_fire_c) begin
            starve_d = '0;
        end else if (bus.vrfWriteRequest_valid && !force_c) begin
            starve_d = starve_q + STARVE_WIDTH'(1);
        end

        if (rd_fire_c) begin
            rd_data_d = mem_q[rd_addr_c];
        end

        if (wr_fire_c && bus.vrfWriteRequest_bits_last) begin
            done_idx_d = bus.vrfWriteRequest_bits_instructionIndex;
        end
    end

    // Control/output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            done_valid_q <= 1'b0;
            done_idx_q   <= '0;
        end else begin
            starve_q     <= starve_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            done_valid_q <= done_valid_d;
            done_idx_q   <= done_idx_d;
        end
    end

    // Register-file storage, cleared on reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_fire_c) begin
            mem_q[wr_addr_c] <= wr_word_c;
        end
    end

    assign bus.readResult_valid                = rd_valid_q;
    assign bus.readResult_bits                 = rd_data_q;
    assign bus.writeDone_valid                 = done_valid_q;
    assign bus.writeDone_bits_instructionIndex = done_idx_q;

endmodule

// File: tb/tb_lane_vrf_write_sink.sv
// Self-checking bench for lane_vrf_write_sink: directed scenarios plus
// randomized traffic against a behavioural model of the register slice.
module tb_lane_vrf_write_sink;
    localparam int unsigned LIMIT = 2;

    logic clock;
    logic reset;

    lane_vrf_write_sink_if bus ();

    lane_vrf_write_sink dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int unsigned mem_m [256];
    int          losses;
    bit          exp_rv;
    int unsigned exp_rd;
    bit          exp_wd;
    int unsigned exp_idx;
    bit          last_wfire;
    bit          last_wready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit rst_n,
                         input bit wv, input int unsigned vd, input int unsigned off,
                         input int unsigned mask, input int unsigned data,
                         input bit last, input int unsigned idx,
                         input bit rv, input int unsigned vs, input int unsigned roff);
        reset                                    = rst_n;
        bus.vrfWriteRequest_valid                = wv;
        bus.vrfWriteRequest_bits_vd              = 5'(vd);
        bus.vrfWriteRequest_bits_offset          = 3'(off);
        bus.vrfWriteRequest_bits_mask            = 4'(mask);
        bus.vrfWriteRequest_bits_data            = data;
        bus.vrfWriteRequest_bits_last            = last;
        bus.vrfWriteRequest_bits_instructionIndex = 3'(idx);
        bus.readRequest_valid                    = rv;
        bus.readRequest_bits_vs                  = 5'(vs);
        bus.readRequest_bits_offset              = 3'(roff);
    endtask

    // One clock cycle: check readies, advance model, check registered outputs.
    task automatic step();
        bit rst_n, wv, rv, w_ok, r_ok, wfire, rfire, last;
        int unsigned waddr, raddr, mask, data, idx, word;
        #1;
        rst_n = reset;
        wv    = bus.vrfWriteRequest_valid;
        rv    = bus.readRequest_valid;
        waddr = {bus.vrfWriteRequest_bits_vd, bus.vrfWriteRequest_bits_offset};
        raddr = {bus.readRequest_bits_vs, bus.readRequest_bits_offset};
        mask  = bus.vrfWriteRequest_bits_mask;
        data  = bus.vrfWriteRequest_bits_data;
        last  = bus.vrfWriteRequest_bits_last;
        idx   = bus.vrfWriteRequest_bits_instructionIndex;
        wfire = 1'b0;
        rfire = 1'b0;
        last_wready = bus.vrfWriteRequest_ready;
        if (rst_n) begin
            // Write goes through if uncontested or once it has lost LIMIT times.
            w_ok = !rv || (losses >= int'(LIMIT));
            r_ok = !(wv && (losses >= int'(LIMIT)));
            check_eq("wr_ready", 32'(bus.vrfWriteRequest_ready), 32'(w_ok));
            check_eq("rd_ready", 32'(bus.readRequest_ready), 32'(r_ok));
            wfire = wv && w_ok;
            rfire = rv && r_ok;
        end
        @(posedge clock);
        #1;
        last_wfire = wfire;
        if (!rst_n) begin
            foreach (mem_m[i]) mem_m[i] = 0;
            losses  = 0;
            exp_rv  = 0;
            exp_rd  = 0;
            exp_wd  = 0;
            exp_idx = 0;
        end else begin
            exp_rv = rfire;
            if (rfire) exp_rd = mem_m[raddr];
            exp_wd = wfire && last;
            if (wfire && last) exp_idx = idx;
            if (wfire) begin
                word = mem_m[waddr];
                for (int b = 0; b < 4; b++)
                    if (mask[b]) word = (word & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
                mem_m[waddr] = word;
                losses = 0;
            end else if (wv) begin
                losses = (losses + 1 > int'(LIMIT)) ? int'(LIMIT) : losses + 1;
            end
        end
        check_eq("rd_valid", 32'(bus.readResult_valid), 32'(exp_rv));
        check_eq("rd_bits", bus.readResult_bits, exp_rd);
        check_eq("wd_valid", 32'(bus.writeDone_valid), 32'(exp_wd));
        check_eq("wd_index", 32'(bus.writeDone_bits_instructionIndex), exp_idx);
        @(negedge clock);
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic do_write(input int unsigned vd, input int unsigned off, input int unsigned mask,
                            input int unsigned data, input bit last, input int unsigned idx);
        drive(1, 1, vd, off, mask, data, last, idx, 0, 0, 0);
        step();
    endtask

    task automatic do_read(input int unsigned vs, input int unsigned off);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, vs, off);
        step();
    endtask

    task automatic do_reset();
        drive(0, 1, 3, 5, 15, 32'hDEADBEEF, 1, 7, 1, 3, 5);
        step();
        step();
    endtask

    initial begin
        int wr_pattern [6] = '{0, 0, 1, 0, 0, 1};
        int fires;
        losses = 0; exp_rv = 0; exp_rd = 0; exp_wd = 0; exp_idx = 0;
        foreach (mem_m[i]) mem_m[i] = 0;

        do_reset();
        check_eq("reset_rv", 32'(bus.readResult_valid), 32'd0);
        check_eq("reset_wd", 32'(bus.writeDone_valid), 32'd0);

        do_read(3, 5);
        check_eq("rd_after_reset_valid", 32'(bus.readResult_valid), 32'd1);
        check_eq("rd_after_reset_bits", bus.readResult_bits, 32'h0);
        check_eq("rd_after_reset_wd", 32'(bus.writeDone_valid), 32'd0);

        do_write(3, 5, 4'hF, 32'h11223344, 0, 0);
        do_write(3, 5, 4'b0101, 32'hAABBCCDD, 0, 0);
        do_read(3, 5);
        check_eq("masked_merge", bus.readResult_bits, 32'h11BB33DD);

        do_write(1, 1, 4'hF, 32'h0, 1, 6);
        check_eq("done_pulse", 32'(bus.writeDone_valid), 32'd1);
        check_eq("done_index", 32'(bus.writeDone_bits_instructionIndex), 32'd6);
        idle();
        check_eq("done_one_cycle", 32'(bus.writeDone_valid), 32'd0);
        do_write(3, 5, 4'h0, 32'hFFFFFFFF, 1, 2);
        check_eq("mask0_done", 32'(bus.writeDone_valid), 32'd1);
        check_eq("mask0_index", 32'(bus.writeDone_bits_instructionIndex), 32'd2);
        do_read(3, 5);
        check_eq("mask0_unchanged", bus.readResult_bits, 32'h11BB33DD);

        // Contention: both valid for six cycles from starve=0.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 10, i, 4'hF, 32'h100 + i, 0, 0, 1, 3, 5);
            step();
            check_eq($sformatf("grant_wready_%0d", i), 32'(last_wready), 32'(wr_pattern[i]));
        end
        idle();

        // Full-throughput writes to vd=31.
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            do_write(31, i, 4'hF, 32'hC0DE0000 + 32'(i * 17), 0, 0);
            if (last_wfire) fires++;
        end
        check_eq("b2b_fires", 32'(fires), 32'd8);
        for (int i = 0; i < 8; i++) begin
            do_read(31, i);
            check_eq($sformatf("b2b_rd_%0d", i), bus.readResult_bits, 32'hC0DE0000 + 32'(i * 17));
        end

        // Reset while a write-done and a read result are in flight.
        do_write(31, 0, 4'hF, 32'h12345678, 1, 5);
        do_read(31, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("mid_reset_rv", 32'(bus.readResult_valid), 32'd0);
        check_eq("mid_reset_wd", 32'(bus.writeDone_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_read(31, i);
            check_eq($sformatf("post_reset_rd_%0d", i), bus.readResult_bits, 32'h0);
        end

        // Randomized traffic over a small address set to force hits.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 2) != 0), $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 15), $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
                  ($urandom_range(0, 1) != 0), $urandom_range(0, 3), $urandom_range(0, 7));
            step();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
